led_color_capture_sequencer: RTL and testbench
==============================================

Name: led_color_capture_sequencer

Overview:
- Calibration-time controller that walks every LED ID and fills led_color_buffer with one averaged camera colour per LED.
- For each LED it:
  - fetches that LED's pixel position from the calibration lookup over a req/valid handshake;
  - drives the LED ID to the id_shower path;
  - waits a number of settle frames;
  - averages the RGB565 pixel at that position over several frames;
  - issues one write into the buffer's pixel-clock port.
- Sits in the clk_pixel domain between the calibration FSM, the lookup table and led_color_buffer.

Parameters:
NUM_LEDS, 50, number of LEDs to sequence
LED_ADDRESS_WIDTH, 10, LED index/address width
CAMERA_COLOR_WIDTH, 16, camera pixel width (RGB565 only)
H_WIDTH, 11, hcount width
V_WIDTH, 10, vcount width
SETTLE_FRAMES, 2, full frames discarded after LED change (0 allowed)
AVG_FRAMES, 4, frames averaged; power of two, 1..16

Ports:
clk_pixel  in  1  HDMI pixel clock
rst_n  in  1  synchronous active-low reset
start_in  in  1  pulse: begin a full sweep
new_frame_in  in  1  one-cycle pulse at frame start
pixel_valid_in  in  1  camera pixel valid
hcount_in  in  H_WIDTH  pixel column
vcount_in  in  V_WIDTH  pixel row
pixel_in  in  16  RGB565 pixel
pos_req_out  out  1  one-cycle position request
pos_led_out  out  LED_ADDRESS_WIDTH  LED index requested
pos_valid_in  in  1  position response valid
pos_h_in  in  H_WIDTH  LED column
pos_v_in  in  V_WIDTH  LED row
led_on_id_out  out  LED_ADDRESS_WIDTH  LED to illuminate
led_on_valid_out  out  1  led_on_id_out meaningful
led_lookup_address  out  LED_ADDRESS_WIDTH  buffer write address
camera_color  out  CAMERA_COLOR_WIDTH  averaged RGB565
led_color_buffer_enable  out  1  one-cycle write strobe
busy_out  out  1  high from start accept to done
done_out  out  1  one-cycle sweep-complete pulse
miss_out  out  1  sticky: some accumulate frame had no matching pixel

Behaviour:
- Reset: one clk_pixel domain, synchronous active-low reset rst_n. rst_n=0 at a clock edge forces state IDLE and zeroes every output, counter and accumulator, including mid-sweep; no buffer write occurs.
- States: IDLE, REQ_POS, WAIT_POS, SETTLE, ACCUM, WRITE, DONE.
- IDLE:
  - start_in=1 -> led_idx=0, miss_out cleared, busy_out=1, go to REQ_POS.
  - start_in is ignored in all other states.
- REQ_POS:
  - pos_req_out=1 for exactly one cycle, with pos_led_out=led_idx.
  - led_on_id_out=led_idx and led_on_valid_out=1 from this state until WRITE.
  - Next state WAIT_POS.
- WAIT_POS:
  - Waits an unbounded time for pos_valid_in and latches pos_h_in/pos_v_in.
  - new_frame_in is ignored here.
  - Next state SETTLE with settle_cnt=0.
- SETTLE:
  - Counts new_frame_in pulses.
  - The (SETTLE_FRAMES+1)th pulse moves to ACCUM, with frame_cnt=0 and accumulators cleared.
  - The frame beginning at that pulse is accumulate frame 0.
- Match definition: pixel_valid_in && hcount_in==pos_h && vcount_in==pos_v. Only the first match per frame is summed.
- Same-cycle rule: a match coincident with new_frame_in belongs to the frame starting at that pulse. This includes the SETTLE->ACCUM transition cycle.
- ACCUM:
  - Per-channel sums: R sum 5+log2(AVG_FRAMES) bits, G sum 6+log2(AVG_FRAMES) bits, B sum 5+log2(AVG_FRAMES) bits; no overflow possible.
  - On new_frame_in: if the ending frame had no match, set miss_out (that frame contributes 0). Then, if frame_cnt==AVG_FRAMES-1 go to WRITE, else increment frame_cnt.
- WRITE (one cycle):
  - led_color_buffer_enable=1, led_lookup_address=led_idx.
  - camera_color = {Rsum>>k, Gsum>>k, Bsum>>k}, with k=log2(AVG_FRAMES) and the shifts truncating.
  - led_lookup_address and camera_color hold until the next WRITE.
  - If led_idx==NUM_LEDS-1 go to DONE; else increment led_idx and go to REQ_POS.
  - led_on_valid_out drops in this cycle.
- DONE: done_out=1 for one cycle, busy_out=0, next state IDLE.
- Per-LED latency: 1 + lookup latency + (SETTLE_FRAMES+1+AVG_FRAMES) frame boundaries + 1.

Decomposition:
- Package led_cal_pkg holds:
  - state enum cap_state_t;
  - RGB565 field constants (R_MSB=15, R_LSB=11, G_MSB=10, G_LSB=5, B_MSB=4, B_LSB=0).
- Sub-module rgb565_accumulator handles clear, add, and averaged output (parameter AVG_FRAMES).

Test Plan:
- Colour and sweep order: NUM_LEDS=2, SETTLE_FRAMES=1, AVG_FRAMES=4, constant pixel 16'hF800 at the position -> exactly two writes:
  - addr 0 then addr 1, colour 16'hF800;
  - each write after the 6th new_frame following pos_valid;
  - done_out one cycle after the second write.
- Averaging: R samples 4, 8, 12, 16 (G=B=0) across four frames -> camera_color=16'h5000. G samples 1, 1, 1, 2 -> G=1 (truncation).
- Off-screen position: pos_h=2000, never matched -> camera_color=0, miss_out=1 until the next start_in.
- Lookup latency: pos_valid_in delayed 5 cycles with a new_frame pulse inside that wait -> that pulse is not counted toward settle; one pos_req_out pulse only.
- Reset mid-ACCUM: rst_n=0 for one cycle -> all outputs 0 on the following edge, no write. A new start_in restarts at LED 0.
- Ignored start and boundary match:
  - start_in while busy -> no effect.
  - Match coincident with new_frame on the SETTLE->ACCUM edge -> counted in frame 0.

Source files
------------

// File: rtl/led_cal_pkg.sv
// Shared types and RGB565 field positions for the LED colour capture path.
package led_cal_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REQ_POS  = 3'd1,
    WAIT_POS = 3'd2,
    SETTLE   = 3'd3,
    ACCUM    = 3'd4,
    WRITE    = 3'd5,
    DONE     = 3'd6
  } cap_state_t;

  localparam int unsigned RGB565_W = 16;
  localparam int unsigned R_MSB    = 15;
  localparam int unsigned R_LSB    = 11;
  localparam int unsigned G_MSB    = 10;
  localparam int unsigned G_LSB    = 5;
  localparam int unsigned B_MSB    = 4;
  localparam int unsigned B_LSB    = 0;

endpackage

// File: rtl/rgb565_accumulator.sv
// Per-channel RGB565 running sums with a truncating power-of-two average.
module rgb565_accumulator
  import led_cal_pkg::*;
#(
  parameter int unsigned AVG_FRAMES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                add,
  input  logic [RGB565_W-1:0] pixel,
  output logic [RGB565_W-1:0] avg_c
);

  localparam int unsigned K  = $clog2(AVG_FRAMES);
  localparam int unsigned RW = 5 + K;
  localparam int unsigned GW = 6 + K;
  localparam int unsigned BW = 5 + K;

  logic [RW-1:0] r_sum_q, r_sum_d;
  logic [GW-1:0] g_sum_q, g_sum_d;
  logic [BW-1:0] b_sum_q, b_sum_d;

  // Clear and add may coincide: the sample then starts a fresh sum.
  always_comb begin
    r_sum_d = clear ? '0 : r_sum_q;
    g_sum_d = clear ? '0 : g_sum_q;
    b_sum_d = clear ? '0 : b_sum_q;
    if (add) begin
      r_sum_d = r_sum_d + RW'(pixel[R_MSB:R_LSB]);
      g_sum_d = g_sum_d + GW'(pixel[G_MSB:G_LSB]);
      b_sum_d = b_sum_d + BW'(pixel[B_MSB:B_LSB]);
    end
  end

  // Sum registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sum_q <= '0;
      g_sum_q <= '0;
      b_sum_q <= '0;
    end else begin
      r_sum_q <= r_sum_d;
      g_sum_q <= g_sum_d;
      b_sum_q <= b_sum_d;
    end
  end

  // Average is a plain right shift, truncating toward zero.
  always_comb begin
    avg_c = {5'(r_sum_q >> K), 6'(g_sum_q >> K), 5'(b_sum_q >> K)};
  end

endmodule

// File: rtl/led_color_capture_sequencer.sv
// Walks every LED, fetches its pixel position, settles, averages the camera
// colour at that position and writes it into the LED colour buffer.
module led_color_capture_sequencer
  import led_cal_pkg::*;
#(
  parameter int unsigned NUM_LEDS           = 50,
  parameter int unsigned LED_ADDRESS_WIDTH  = 10,
  parameter int unsigned CAMERA_COLOR_WIDTH = 16,
  parameter int unsigned H_WIDTH            = 11,
  parameter int unsigned V_WIDTH            = 10,
  parameter int unsigned SETTLE_FRAMES      = 2,
  parameter int unsigned AVG_FRAMES         = 4
) (
  input  logic                          clk_pixel,
  input  logic                          rst_n,
  input  logic                          start_in,
  input  logic                          new_frame_in,
  input  logic                          pixel_valid_in,
  input  logic [H_WIDTH-1:0]            hcount_in,
  input  logic [V_WIDTH-1:0]            vcount_in,
  input  logic [15:0]                   pixel_in,
  output logic                          pos_req_out,
  output logic [LED_ADDRESS_WIDTH-1:0]  pos_led_out,
  input  logic                          pos_valid_in,
  input  logic [H_WIDTH-1:0]            pos_h_in,
  input  logic [V_WIDTH-1:0]            pos_v_in,
  output logic [LED_ADDRESS_WIDTH-1:0]  led_on_id_out,
  output logic                          led_on_valid_out,
  output logic [LED_ADDRESS_WIDTH-1:0]  led_lookup_address,
  output logic [CAMERA_COLOR_WIDTH-1:0] camera_color,
  output logic                          led_color_buffer_enable,
  output logic                          busy_out,
  output logic                          done_out,
  output logic                          miss_out
);

  localparam int unsigned AW  = LED_ADDRESS_WIDTH;
  localparam int unsigned CW  = CAMERA_COLOR_WIDTH;
  localparam int unsigned SCW = $clog2(SETTLE_FRAMES + 2);
  localparam int unsigned FCW = $clog2(AVG_FRAMES + 1);
  localparam logic [AW-1:0]  LAST_IDX   = AW'(NUM_LEDS - 1);
  localparam logic [SCW-1:0] SETTLE_END = SCW'(SETTLE_FRAMES);
  localparam logic [FCW-1:0] FRAME_END  = FCW'(AVG_FRAMES - 1);

  cap_state_t state_q, state_d;
  logic [AW-1:0]      led_idx_q, led_idx_d;
  logic [H_WIDTH-1:0] pos_h_q, pos_h_d;
  logic [V_WIDTH-1:0] pos_v_q, pos_v_d;
  logic [SCW-1:0]     settle_cnt_q, settle_cnt_d;
  logic [FCW-1:0]     frame_cnt_q, frame_cnt_d;
  logic               matched_q, matched_d;
  logic               miss_q, miss_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pos_req_q, pos_req_d;
  logic [AW-1:0]      pos_led_q, pos_led_d;
  logic [AW-1:0]      led_on_id_q, led_on_id_d;
  logic               led_on_valid_q, led_on_valid_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [CW-1:0]      color_q, color_d;
  logic               wr_en_q, wr_en_d;

  logic               pix_match;
  logic [AW-1:0]      led_idx_inc;
  logic               acc_clear;
  logic               acc_add;
  logic [15:0]        acc_avg_c;

  rgb565_accumulator #(
    .AVG_FRAMES(AVG_FRAMES)
  ) u_acc (
    .clk   (clk_pixel),
    .rst_n (rst_n),
    .clear (acc_clear),
    .add   (acc_add),
    .pixel (pixel_in),
    .avg_c (acc_avg_c)
  );

  // Next-state and registered-output logic; outputs are set on state entry.
  always_comb begin
    state_d        = state_q;
    led_idx_d      = led_idx_q;
    pos_h_d        = pos_h_q;
    pos_v_d        = pos_v_q;
    settle_cnt_d   = settle_cnt_q;
    frame_cnt_d    = frame_cnt_q;
    matched_d      = matched_q;
    miss_d         = miss_q;
    busy_d         = busy_q;
    done_d         = 1'b0;
    pos_req_d      = 1'b0;
    pos_led_d      = pos_led_q;
    led_on_id_d    = led_on_id_q;
    led_on_valid_d = led_on_valid_q;
    addr_d         = addr_q;
    color_d        = color_q;
    wr_en_d        = 1'b0;
    acc_clear      = 1'b0;
    acc_add        = 1'b0;
    pix_match      = pixel_valid_in && (hcount_in == pos_h_q) && (vcount_in == pos_v_q);
    led_idx_inc    = led_idx_q + AW'(1);

    case (state_q)
      IDLE: begin
        if (start_in) begin
          state_d        = REQ_POS;
          led_idx_d      = '0;
          miss_d         = 1'b0;
          busy_d         = 1'b1;
          pos_req_d      = 1'b1;
          pos_led_d      = '0;
          led_on_id_d    = '0;
          led_on_valid_d = 1'b1;
        end
      end
      REQ_POS: begin
        state_d = WAIT_POS;
      end
      WAIT_POS: begin
        if (pos_valid_in) begin
          state_d      = SETTLE;
          pos_h_d      = pos_h_in;
          pos_v_d      = pos_v_in;
          settle_cnt_d = '0;
        end
      end
      SETTLE: begin
        if (new_frame_in) begin
          if (settle_cnt_q == SETTLE_END) begin
            // This pulse opens accumulate frame 0, including a same-cycle match.
            state_d     = ACCUM;
            frame_cnt_d = '0;
            acc_clear   = 1'b1;
            acc_add     = pix_match;
            matched_d   = pix_match;
          end else begin
            settle_cnt_d = settle_cnt_q + SCW'(1);
          end
        end
      end
      ACCUM: begin
        if (new_frame_in) begin
          if (!matched_q) begin
            miss_d = 1'b1;
          end
          if (frame_cnt_q == FRAME_END) begin
            state_d        = WRITE;
            wr_en_d        = 1'b1;
            addr_d         = led_idx_q;
            color_d        = CW'(acc_avg_c);
            led_on_valid_d = 1'b0;
          end else begin
            frame_cnt_d = frame_cnt_q + FCW'(1);
            acc_add     = pix_match;
            matched_d   = pix_match;
          end
        end else if (pix_match && !matched_q) begin
          acc_add   = 1'b1;
          matched_d = 1'b1;
        end
      end
      WRITE: begin
        if (led_idx_q == LAST_IDX) begin
          state_d = DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          state_d        = REQ_POS;
          led_idx_d      = led_idx_inc;
          pos_req_d      = 1'b1;
          pos_led_d      = led_idx_inc;
          led_on_id_d    = led_idx_inc;
          led_on_valid_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_pixel) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      led_idx_q      <= '0;
      pos_h_q        <= '0;
      pos_v_q        <= '0;
      settle_cnt_q   <= '0;
      frame_cnt_q    <= '0;
      matched_q      <= 1'b0;
      miss_q         <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      pos_req_q      <= 1'b0;
      pos_led_q      <= '0;
      led_on_id_q    <= '0;
      led_on_valid_q <= 1'b0;
      addr_q         <= '0;
      color_q        <= '0;
      wr_en_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      led_idx_q      <= led_idx_d;
      pos_h_q        <= pos_h_d;
      pos_v_q        <= pos_v_d;
      settle_cnt_q   <= settle_cnt_d;
      frame_cnt_q    <= frame_cnt_d;
      matched_q      <= matched_d;
      miss_q         <= miss_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      pos_req_q      <= pos_req_d;
      pos_led_q      <= pos_led_d;
      led_on_id_q    <= led_on_id_d;
      led_on_valid_q <= led_on_valid_d;
      addr_q         <= addr_d;
      color_q        <= color_d;
      wr_en_q        <= wr_en_d;
    end
  end

  assign pos_req_out             = pos_req_q;
  assign pos_led_out             = pos_led_q;
  assign led_on_id_out           = led_on_id_q;
  assign led_on_valid_out        = led_on_valid_q;
  assign led_lookup_address      = addr_q;
  assign camera_color            = color_q;
  assign led_color_buffer_enable = wr_en_q;
  assign busy_out                = busy_q;
  assign done_out                = done_q;
  assign miss_out                = miss_q;

endmodule

// File: tb/tb_led_color_capture_sequencer.sv
// Self-checking bench: two-LED sweeps with a write scoreboard.
module tb_led_color_capture_sequencer;

  localparam int unsigned NL  = 2;
  localparam int unsigned AW  = 10;
  localparam int unsigned HW  = 11;
  localparam int unsigned VW  = 10;
  localparam int unsigned SF  = 1;
  localparam int unsigned AF  = 4;
  localparam logic [HW-1:0] PIX_H = 11'd100;
  localparam logic [VW-1:0] PIX_V = 10'd50;

  logic          clk_pixel = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_in = 1'b0;
  logic          new_frame_in = 1'b0;
  logic          pixel_valid_in = 1'b0;
  logic [HW-1:0] hcount_in = '0;
  logic [VW-1:0] vcount_in = '0;
  logic [15:0]   pixel_in = '0;
  logic          pos_valid_in = 1'b0;
  logic [HW-1:0] pos_h_in = '0;
  logic [VW-1:0] pos_v_in = '0;
  logic          pos_req_out;
  logic [AW-1:0] pos_led_out;
  logic [AW-1:0] led_on_id_out;
  logic          led_on_valid_out;
  logic [AW-1:0] led_lookup_address;
  logic [15:0]   camera_color;
  logic          led_color_buffer_enable;
  logic          busy_out;
  logic          done_out;
  logic          miss_out;

  always #5 clk_pixel = ~clk_pixel;

  led_color_capture_sequencer #(
    .NUM_LEDS(NL), .LED_ADDRESS_WIDTH(AW), .CAMERA_COLOR_WIDTH(16),
    .H_WIDTH(HW), .V_WIDTH(VW), .SETTLE_FRAMES(SF), .AVG_FRAMES(AF)
  ) dut (
    .clk_pixel(clk_pixel), .rst_n(rst_n), .start_in(start_in),
    .new_frame_in(new_frame_in), .pixel_valid_in(pixel_valid_in),
    .hcount_in(hcount_in), .vcount_in(vcount_in), .pixel_in(pixel_in),
    .pos_req_out(pos_req_out), .pos_led_out(pos_led_out),
    .pos_valid_in(pos_valid_in), .pos_h_in(pos_h_in), .pos_v_in(pos_v_in),
    .led_on_id_out(led_on_id_out), .led_on_valid_out(led_on_valid_out),
    .led_lookup_address(led_lookup_address), .camera_color(camera_color),
    .led_color_buffer_enable(led_color_buffer_enable),
    .busy_out(busy_out), .done_out(done_out), .miss_out(miss_out)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [15:0]   color;
  } wr_t;

  wr_t  exp_q[$];
  wr_t  got_e;
  int   checks = 0;
  int   errors = 0;
  int   req_cnt = 0;
  int   req0 = 0;
  logic exp_miss = 1'b0;

  // Write scoreboard and request-pulse counter.
  always @(negedge clk_pixel) begin
    if (led_color_buffer_enable) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr=%0d color=%h", led_lookup_address, camera_color);
      end else begin
        got_e = exp_q.pop_front();
        if (led_lookup_address !== got_e.addr || camera_color !== got_e.color) begin
          errors++;
          $display("FAIL write_data got addr=%0d color=%h exp addr=%0d color=%h",
                   led_lookup_address, camera_color, got_e.addr, got_e.color);
        end
      end
    end
    if (pos_req_out) req_cnt++;
  end

  task automatic drive_pix(input logic [HW-1:0] h, input logic [VW-1:0] v, input logic [15:0] p);
    pixel_valid_in = 1'b1;
    hcount_in      = h;
    vcount_in      = v;
    pixel_in       = p;
  endtask

  task automatic clear_pix();
    pixel_valid_in = 1'b0;
    pixel_in       = '0;
  endtask

  task automatic start_sweep();
    req0     = req_cnt;
    start_in = 1'b1;
    @(negedge clk_pixel);
    start_in = 1'b0;
    exp_miss = 1'b0;
    checks++;
    if (busy_out !== 1'b1 || miss_out !== 1'b0) begin
      errors++;
      $display("FAIL start_accept busy=%b miss=%b exp busy=1 miss=0", busy_out, miss_out);
    end
  endtask

  task automatic end_sweep();
    checks++;
    if (req_cnt - req0 != NL || miss_out !== exp_miss) begin
      errors++;
      $display("FAIL sweep_end req_pulses=%0d miss=%b exp req_pulses=%0d miss=%b",
               req_cnt - req0, miss_out, NL, exp_miss);
    end
    repeat (3) @(negedge clk_pixel);
  endtask

  // One LED: lookup handshake, settle, accumulate; optional reset at pulse abort_p.
  task automatic run_led(input int idx, input logic [HW-1:0] rh, input logic [VW-1:0] rv,
                         input int delay, input logic [3:0][15:0] pix, input logic [3:0] hit,
                         input bit boundary, input bit last, input int abort_p,
                         input bit poke_start);
    int n;
    int f;
    logic [6:0] rs;
    logic [7:0] gs;
    logic [6:0] bs;
    wr_t e;
    n = 0;
    while (!pos_req_out && n < 50) begin
      @(negedge clk_pixel);
      n++;
    end
    checks++;
    if (pos_req_out !== 1'b1 || pos_led_out !== AW'(idx) || led_on_id_out !== AW'(idx) ||
        led_on_valid_out !== 1'b1) begin
      errors++;
      $display("FAIL pos_req led%0d req=%b pos_led=%0d on_id=%0d on_valid=%b exp 1/%0d/%0d/1",
               idx, pos_req_out, pos_led_out, led_on_id_out, led_on_valid_out, idx, idx);
    end
    for (int i = 0; i < delay; i++) begin
      if (delay >= 3 && i == delay / 2) new_frame_in = 1'b1;
      if (poke_start && i == 0) start_in = 1'b1;
      @(negedge clk_pixel);
      new_frame_in = 1'b0;
      start_in     = 1'b0;
    end
    pos_valid_in = 1'b1;
    pos_h_in     = rh;
    pos_v_in     = rv;
    @(negedge clk_pixel);
    pos_valid_in = 1'b0;
    pos_h_in     = '0;
    pos_v_in     = '0;

    rs = '0;
    gs = '0;
    bs = '0;
    for (int k = 0; k < 4; k++) begin
      if (hit[k] && rh == PIX_H && rv == PIX_V) begin
        rs = rs + 7'(pix[k][15:11]);
        gs = gs + 8'(pix[k][10:5]);
        bs = bs + 7'(pix[k][4:0]);
      end else begin
        exp_miss = 1'b1;
      end
    end

    for (int p = 0; p <= int'(SF + AF); p++) begin
      f = p - int'(SF);
      if (p == abort_p) begin
        rst_n = 1'b0;
        @(negedge clk_pixel);
        rst_n = 1'b1;
        checks++;
        if (pos_req_out !== 1'b0 || pos_led_out !== '0 || led_on_id_out !== '0 ||
            led_on_valid_out !== 1'b0 || led_lookup_address !== '0 || camera_color !== '0 ||
            led_color_buffer_enable !== 1'b0 || busy_out !== 1'b0 || done_out !== 1'b0 ||
            miss_out !== 1'b0) begin
          errors++;
          $display("FAIL mid_reset_zero req=%b led=%0d id=%0d v=%b addr=%0d col=%h we=%b busy=%b done=%b miss=%b exp all 0",
                   pos_req_out, pos_led_out, led_on_id_out, led_on_valid_out, led_lookup_address,
                   camera_color, led_color_buffer_enable, busy_out, done_out, miss_out);
        end
        return;
      end
      if (p == int'(SF + AF)) begin
        e.addr  = AW'(idx);
        e.color = {5'(rs / 7'd4), 6'(gs / 8'd4), 5'(bs / 7'd4)};
        exp_q.push_back(e);
      end
      new_frame_in = 1'b1;
      if (boundary && f == 0 && hit[0]) drive_pix(PIX_H, PIX_V, pix[0]);
      @(negedge clk_pixel);
      new_frame_in = 1'b0;
      clear_pix();
      if (p == int'(SF + AF)) begin
        checks++;
        if (led_color_buffer_enable !== 1'b1 || led_on_valid_out !== 1'b0) begin
          errors++;
          $display("FAIL write_timing led%0d we=%b on_valid=%b exp we=1 on_valid=0",
                   idx, led_color_buffer_enable, led_on_valid_out);
        end
        if (last) begin
          @(negedge clk_pixel);
          checks++;
          if (done_out !== 1'b1 || busy_out !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse done=%b busy=%b exp done=1 busy=0", done_out, busy_out);
          end
        end
      end else begin
        drive_pix(11'(PIX_H + 11'd1), PIX_V, 16'h07E0);
        @(negedge clk_pixel);
        if (f < 0) drive_pix(PIX_H, PIX_V, 16'hFFFF);
        else if (hit[f] && !(boundary && f == 0)) drive_pix(PIX_H, PIX_V, pix[f]);
        else if (hit[f]) drive_pix(PIX_H, PIX_V, 16'hFFFF);
        else clear_pix();
        @(negedge clk_pixel);
        if (f >= 0 && hit[f]) drive_pix(PIX_H, PIX_V, 16'hFFFF);
        else clear_pix();
        @(negedge clk_pixel);
        clear_pix();
        @(negedge clk_pixel);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk_pixel);
    checks++;
    if (pos_req_out !== 1'b0 || led_on_valid_out !== 1'b0 || led_color_buffer_enable !== 1'b0 ||
        busy_out !== 1'b0 || done_out !== 1'b0 || miss_out !== 1'b0 || camera_color !== '0 ||
        led_lookup_address !== '0 || pos_led_out !== '0 || led_on_id_out !== '0) begin
      errors++;
      $display("FAIL reset_state req=%b v=%b we=%b busy=%b done=%b miss=%b col=%h exp all 0",
               pos_req_out, led_on_valid_out, led_color_buffer_enable, busy_out, done_out,
               miss_out, camera_color);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk_pixel);
  endtask

  task automatic test_sweep_color();
    start_sweep();
    run_led(0, PIX_H, PIX_V, 1, {4{16'hF800}}, 4'b1111, 1'b0, 1'b0, -1, 1'b0);
    run_led(1, PIX_H, PIX_V, 1, {4{16'hF800}}, 4'b1111, 1'b0, 1'b1, -1, 1'b0);
    end_sweep();
  endtask

  task automatic test_averaging_latency();
    start_sweep();
    run_led(0, PIX_H, PIX_V, 1, {16'h8000, 16'h6000, 16'h4000, 16'h2000}, 4'b1111,
            1'b0, 1'b0, -1, 1'b0);
    run_led(1, PIX_H, PIX_V, 5, {16'h0040, 16'h0020, 16'h0020, 16'h0020}, 4'b1111,
            1'b0, 1'b1, -1, 1'b0);
    end_sweep();
  endtask

  task automatic test_offscreen();
    start_sweep();
    run_led(0, 11'd2000, PIX_V, 2, {4{16'hF800}}, 4'b1111, 1'b0, 1'b0, -1, 1'b0);
    run_led(1, PIX_H, PIX_V, 1, {4{16'h001F}}, 4'b1111, 1'b0, 1'b1, -1, 1'b0);
    end_sweep();
    checks++;
    if (miss_out !== 1'b1) begin
      errors++;
      $display("FAIL miss_sticky miss=%b exp 1", miss_out);
    end
  endtask

  task automatic test_reset_mid_accum();
    start_sweep();
    run_led(0, PIX_H, PIX_V, 1, {4{16'hF800}}, 4'b1111, 1'b0, 1'b0, 3, 1'b0);
    for (int i = 0; i < 8; i++) begin
      new_frame_in = 1'b1;
      drive_pix(PIX_H, PIX_V, 16'hF800);
      @(negedge clk_pixel);
      new_frame_in = 1'b0;
      clear_pix();
      repeat (3) @(negedge clk_pixel);
    end
    checks++;
    if (busy_out !== 1'b0 || pos_req_out !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle busy=%b req=%b exp 0/0", busy_out, pos_req_out);
    end
    start_sweep();
    run_led(0, PIX_H, PIX_V, 1, {4{16'h7BEF}}, 4'b1111, 1'b0, 1'b0, -1, 1'b0);
    run_led(1, PIX_H, PIX_V, 1, {4{16'h0841}}, 4'b1111, 1'b0, 1'b1, -1, 1'b0);
    end_sweep();
  endtask

  task automatic test_ignored_start_boundary();
    start_sweep();
    run_led(0, PIX_H, PIX_V, 2, {16'h0001, 16'h0001, 16'h0001, 16'h001F}, 4'b1111,
            1'b1, 1'b0, -1, 1'b1);
    run_led(1, PIX_H, PIX_V, 3, {4{16'h07E0}}, 4'b1111, 1'b0, 1'b1, -1, 1'b1);
    end_sweep();
  endtask

  initial begin
    test_reset();
    test_sweep_color();
    test_averaging_latency();
    test_offscreen();
    test_reset_mid_accum();
    test_ignored_start_boundary();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_writes pending=%0d exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
